sc_mux_scan_ctrl: RTL and testbench

- Sequencing controller for the 22:1 registered 8-bit slow-control channel mux.
- Drives the mux select and hold (five_ones) inputs so that the enabled channels are scanned in ascending order, with a fixed number of samples (beats) per channel.
- Presents the mux output to a downstream consumer under a valid/ready handshake. Backpressure is applied by freezing the mux register.
- Sits between the slow-control register bank (mask and burst configuration) and the mux/readout path.

---
 rtl/sc_mux_scan_ctrl.sv | 166 ++++++++++++++++
 tb/tb_sc_mux_scan_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_mux_scan_ctrl.sv
// Scan sequencer for the 22:1 registered slow-control channel mux.
// Walks the enabled channels in ascending order, takes a fixed number of
// beats per channel, and hands each beat downstream under valid/ready.
// Backpressure freezes the mux register through mux_hold_o (five_ones).
module sc_mux_scan_ctrl #(
    parameter int NUM_CH  = 22,
    parameter int SEL_W   = 5,
    parameter int BURST_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               abort_i,
    input  logic               continuous_i,
    input  logic [NUM_CH-1:0]  ch_mask_i,
    input  logic [BURST_W-1:0] burst_len_i,
    output logic [SEL_W-1:0]   mux_sel_o,
    output logic               mux_hold_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [SEL_W-1:0]   out_ch_o,
    output logic               out_last_o,
    output logic               frame_done_o,
    output logic               busy_o,
    output logic               mask_err_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    logic [1:0]         state_q,      state_d;
    logic [SEL_W-1:0]   sel_q,        sel_d;
    logic [NUM_CH-1:0]  mask_q,       mask_d;
    logic [BURST_W-1:0] burst_q,      burst_d;
    logic [BURST_W-1:0] cnt_q,        cnt_d;
    logic               cont_q,       cont_d;
    logic               stop_q,       stop_d;
    logic               frame_done_q, frame_done_d;
    logic               mask_err_q,   mask_err_d;

    // Lowest set bit of mask at index >= from, as {found, index}.
    // Only indices 0..NUM_CH-1 are ever returned, so the select stays in range.
    function automatic logic [SEL_W:0] find_ch(input logic [NUM_CH-1:0] mask,
                                               input int from);
        logic [SEL_W:0] res;
        res = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= from)) res = {1'b1, SEL_W'(i)};
        end
        return res;
    endfunction

    logic [SEL_W:0]     first_in;   // lowest enabled channel of the live mask
    logic [SEL_W:0]     first_sh;   // lowest enabled channel of the shadow mask
    logic [SEL_W:0]     next_sh;    // next enabled channel above the current one
    logic [BURST_W-1:0] burst_eff;  // captured burst with 0 promoted to 1
    logic               last_of_ch; // current beat is the channel's final one

    assign first_in   = find_ch(ch_mask_i, 0);
    assign first_sh   = find_ch(mask_q, 0);
    assign next_sh    = find_ch(mask_q, int'(sel_q) + 1);
    assign burst_eff  = (burst_q == '0) ? BURST_W'(1) : burst_q;
    assign last_of_ch = (cnt_q <= BURST_W'(1));

    // Next-state logic: IDLE -> LOAD -> STREAM, per-channel beats, frame wrap.
    always_comb begin
        // NOTE: every _d signal takes its hold value first, so no branch can leave one unassigned and infer a latch.
        state_d      = state_q;
        sel_d        = sel_q;
        mask_d       = mask_q;
        burst_d      = burst_q;
        cnt_d        = cnt_q;
        cont_d       = cont_q;
        stop_d       = stop_q | (stop_i & (state_q != ST_IDLE));
        frame_done_d = 1'b0;
        mask_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                stop_d = 1'b0;
                if (start_i && !abort_i) begin
                    if (first_in[SEL_W]) begin
                        mask_d  = ch_mask_i;
                        burst_d = burst_len_i;
                        cont_d  = continuous_i;
                        sel_d   = first_in[SEL_W-1:0];
                        state_d = ST_LOAD;
                    end else begin
                        mask_err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_STREAM;
                cnt_d   = burst_eff;
            end
            ST_STREAM: begin
                if (out_ready_i) begin
                    cnt_d = cnt_q - BURST_W'(1);
                    if (last_of_ch) begin
                        if (next_sh[SEL_W]) begin
                            state_d = ST_LOAD;
                            sel_d   = next_sh[SEL_W-1:0];
                        end else begin
                            frame_done_d = 1'b1;
                            if (cont_q && !stop_d) begin
                                state_d = ST_LOAD;
                                sel_d   = first_sh[SEL_W-1:0];
                            end else begin
                                state_d = ST_IDLE;
                                stop_d  = 1'b0;
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything and abandons the frame silently.
        if (abort_i && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            stop_d       = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    // State and shadow registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
        if (rst_i) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            mask_q       <= '0;
            burst_q      <= '0;
            cnt_q        <= '0;
            cont_q       <= 1'b0;
            stop_q       <= 1'b0;
            frame_done_q <= 1'b0;
            mask_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            mask_q       <= mask_d;
            burst_q      <= burst_d;
            cnt_q        <= cnt_d;
            cont_q       <= cont_d;
            stop_q       <= stop_d;
            frame_done_q <= frame_done_d;
            mask_err_q   <= mask_err_d;
        end
    end

    assign mux_sel_o    = sel_q;
    assign out_ch_o     = sel_q;
    assign out_valid_o  = (state_q == ST_STREAM);
    assign out_last_o   = out_valid_o && last_of_ch && !next_sh[SEL_W];
    assign frame_done_o = frame_done_q;
    assign mask_err_o   = mask_err_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign mux_hold_o   = (state_q == ST_LOAD)   ? 1'b0 :
                          (state_q == ST_STREAM) ? ~out_ready_i : 1'b1;

endmodule

// File: tb/tb_sc_mux_scan_ctrl.sv
// Self-checking bench for sc_mux_scan_ctrl. Expected beat sequences are
// derived from the channel mask and burst length (ascending channels,
// burst beats each, last beat flagged) and compared cycle by cycle.
module tb_sc_mux_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, abort, continuous;
    logic [21:0] ch_mask;
    logic [3:0]  burst_len;
    logic [4:0]  mux_sel, out_ch;
    logic        mux_hold, out_valid, out_ready, out_last;
    logic        frame_done, busy, mask_err;

    int vectors     = 0;
    int miscompares = 0;

    sc_mux_scan_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .stop_i       (stop),
        .abort_i      (abort),
        .continuous_i (continuous),
        .ch_mask_i    (ch_mask),
        .burst_len_i  (burst_len),
        .mux_sel_o    (mux_sel),
        .mux_hold_o   (mux_hold),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_ch_o     (out_ch),
        .out_last_o   (out_last),
        .frame_done_o (frame_done),
        .busy_o       (busy),
        .mask_err_o   (mask_err)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive point: just after the rising edge. Sample point: falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        smp();
        vectors++;
        if ({mux_sel, mux_hold, out_valid, out_last, frame_done, mask_err, busy} !== {5'd0, 1'b1, 5'b0}) begin
            miscompares++;
            $display("FAIL reset_state: sel=%0d hold=%b valid=%b last=%b fd=%b merr=%b busy=%b, need sel=0 hold=1 rest 0",
                     mux_sel, mux_hold, out_valid, out_last, frame_done, mask_err, busy);
        end
        step();
        rst = 1'b0;
    endtask

    // One non-continuous frame from start to frame_done, with optional
    // random stalls, a forced stall of stall_len cycles on beat stall_k,
    // and (disturb) random changes of the live config/start during the frame.
    task automatic run_frame(input logic [21:0] mask, input logic [3:0] burst,
                             input int stall_pct, input int stall_k,
                             input int stall_len, input bit disturb);
        int exp_ch[$];
        bit exp_last[$];
        int beff, k, gaps, n_hold, cyc, nch;
        exp_ch.delete();
        exp_last.delete();
        beff = (burst == 0) ? 1 : int'(burst);
        nch  = $countones(mask);
        for (int c = 0; c < 22; c++)
            if (mask[c])
                for (int b = 0; b < beff; b++) begin
                    exp_ch.push_back(c);
                    exp_last.push_back(1'b0);
                end
        exp_last[exp_last.size() - 1] = 1'b1;

        ch_mask = mask; burst_len = burst; continuous = 1'b0; out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        smp();
        vectors++;
        if (!(busy === 1'b1 && out_valid === 1'b0 && mux_hold === 1'b0 && mux_sel === 5'(exp_ch[0]))) begin
            miscompares++;
            $display("FAIL load_after_start: busy=%b valid=%b hold=%b sel=%0d, need 1 0 0 %0d",
                     busy, out_valid, mux_hold, mux_sel, exp_ch[0]);
        end

        k = 0; gaps = 1; n_hold = 0; cyc = 0;
        while (k < exp_ch.size() && cyc < 4000) begin
            step();
            cyc++;
            if (k == stall_k && n_hold < stall_len) out_ready = 1'b0;
            else out_ready = ($urandom_range(0, 99) >= stall_pct);
            if (disturb) begin
                ch_mask    = 22'($urandom());
                burst_len  = 4'($urandom());
                continuous = 1'($urandom());
                start      = ($urandom_range(0, 7) == 0);
            end
            smp();
            if (out_valid === 1'b1) begin
                vectors++;
                if (out_ch !== 5'(exp_ch[k]) || out_last !== exp_last[k] || mux_sel !== out_ch
                    || mux_hold !== ~out_ready || frame_done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL beat%0d: ch=%0d last=%b sel=%0d hold=%b fd=%b, need ch=%0d last=%b sel=ch hold=%b fd=0",
                             k, out_ch, out_last, mux_sel, mux_hold, frame_done, exp_ch[k], exp_last[k], ~out_ready);
                end
                if (!out_ready) n_hold++;
                else k++;
            end else begin
                gaps++;
                vectors++;
                if (busy !== 1'b1 || mux_hold !== 1'b0 || mux_sel !== 5'(exp_ch[k]) || frame_done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL gap_before_beat%0d: busy=%b hold=%b sel=%0d fd=%b, need 1 0 %0d 0",
                             k, busy, mux_hold, mux_sel, frame_done, exp_ch[k]);
                end
            end
        end
        start = 1'b0; continuous = 1'b0; out_ready = 1'b1;
        vectors++;
        if (k != exp_ch.size()) begin
            miscompares++;
            $display("FAIL frame_timeout: %0d beats accepted, need %0d", k, exp_ch.size());
        end
        vectors++;
        if (gaps != nch) begin
            miscompares++;
            $display("FAIL load_cycles: %0d, need %0d", gaps, nch);
        end
        if (stall_pct == 0 && stall_len > 0) begin
            vectors++;
            if (n_hold != stall_len) begin
                miscompares++;
                $display("FAIL stall_hold_cycles: %0d, need %0d", n_hold, stall_len);
            end
        end
        step();
        smp();
        vectors++;
        if (frame_done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || mux_hold !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_end: fd=%b busy=%b valid=%b hold=%b, need 1 0 0 1",
                     frame_done, busy, out_valid, mux_hold);
        end
        step();
        smp();
        vectors++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_done_pulse: fd=%b busy=%b, need 0 0", frame_done, busy);
        end
        step();
    endtask

    task automatic test_basic();
        run_frame(22'h000005, 4'd2, 0, -1, 0, 1'b0);
    endtask

    task automatic test_stall();
        run_frame(22'h000005, 4'd2, 0, 2, 3, 1'b0);
    endtask

    task automatic test_continuous_stop();
        int stop_cyc, beats_total, beats_after, fd_cnt, cyc;
        bit ended;
        stop_cyc = $urandom_range(4, 12);
        beats_total = 0; beats_after = 0; fd_cnt = 0; ended = 1'b0;
        ch_mask = 22'h200000; burst_len = 4'd0; continuous = 1'b1; out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0; continuous = 1'b0;
        for (cyc = 0; cyc < 60; cyc++) begin
            stop = (cyc == stop_cyc);
            smp();
            vectors++;
            if (mux_sel > 5'd21 || (out_valid === 1'b1 && (out_ch !== 5'd21 || out_last !== 1'b1))) begin
                miscompares++;
                $display("FAIL cont_beat cyc%0d: sel=%0d ch=%0d last=%b, need sel<=21 ch=21 last=1",
                         cyc, mux_sel, out_ch, out_last);
            end
            if (out_valid === 1'b1) begin
                beats_total++;
                if (cyc >= stop_cyc) beats_after++;
            end
            if (frame_done === 1'b1) fd_cnt++;
            if (cyc > stop_cyc && busy === 1'b0) begin
                ended = 1'b1;
                break;
            end
            step();
        end
        stop = 1'b0;
        vectors++;
        if (!ended || beats_after != 1 || beats_total < 2 || fd_cnt != beats_total) begin
            miscompares++;
            $display("FAIL cont_stop: ended=%b beats_after_stop=%0d total=%0d frame_done=%0d, need 1 1 >=2 frame_done==total",
                     ended, beats_after, beats_total, fd_cnt);
        end
        step();
        smp();
        vectors++;
        if (busy !== 1'b0 || mux_hold !== 1'b1 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL cont_idle: busy=%b hold=%b fd=%b, need 0 1 0", busy, mux_hold, frame_done);
        end
        step();
    endtask

    // A fresh continuous frame after a stop must run freely (stop not sticky).
    task automatic test_continuous_restart();
        int beats;
        beats = 0;
        ch_mask = 22'h200000; burst_len = 4'd0; continuous = 1'b1; out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0; continuous = 1'b0;
        for (int i = 0; i < 8; i++) begin
            smp();
            if (out_valid === 1'b1) beats++;
            step();
        end
        vectors++;
        if (beats != 4) begin
            miscompares++;
            $display("FAIL cont_restart_beats: %0d, need 4", beats);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        smp();
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL cont_abort: busy=%b valid=%b, need 0 0", busy, out_valid);
        end
        step();
    endtask

    task automatic test_mask_err();
        ch_mask = 22'h0; burst_len = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        smp();
        vectors++;
        if (mask_err !== 1'b1 || busy !== 1'b0 || mux_hold !== 1'b1) begin
            miscompares++;
            $display("FAIL mask_err_pulse: merr=%b busy=%b hold=%b, need 1 0 1", mask_err, busy, mux_hold);
        end
        step();
        smp();
        vectors++;
        if (mask_err !== 1'b0 || busy !== 1'b0 || mux_hold !== 1'b1) begin
            miscompares++;
            $display("FAIL mask_err_single: merr=%b busy=%b hold=%b, need 0 0 1", mask_err, busy, mux_hold);
        end
        ch_mask = 22'h000005; start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        smp();
        vectors++;
        if (busy !== 1'b0 || mux_hold !== 1'b1 || mask_err !== 1'b0) begin
            miscompares++;
            $display("FAIL start_with_abort: busy=%b hold=%b merr=%b, need 0 1 0", busy, mux_hold, mask_err);
        end
        step();
    endtask

    task automatic test_abort();
        bit found;
        found = 1'b0;
        ch_mask = 22'h3FFFFF; burst_len = 4'd3; out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            smp();
            if (out_valid === 1'b1 && out_ch === 5'd7) begin
                found = 1'b1;
                break;
            end
            step();
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL abort_reach_ch7: channel 7 beat not seen within 200 cycles");
        end
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        smp();
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || mux_hold !== 1'b1 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle: busy=%b valid=%b hold=%b fd=%b, need 0 0 1 0",
                     busy, out_valid, mux_hold, frame_done);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            smp();
            vectors++;
            if (frame_done !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_no_done: fd=%b busy=%b, need 0 0", frame_done, busy);
            end
        end
        step();
        run_frame(22'h3FFFFF, 4'd3, 0, -1, 0, 1'b0);
    endtask

    task automatic test_reset_mid_stream();
        ch_mask = 22'h00F0F0; burst_len = 4'd3; out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        smp();
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_stream: valid=%b, need 1", out_valid);
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        smp();
        vectors++;
        if (mux_sel !== 5'd0 || mux_hold !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_stream: sel=%0d hold=%b valid=%b busy=%b fd=%b, need 0 1 0 0 0",
                     mux_sel, mux_hold, out_valid, busy, frame_done);
        end
        step();
        smp();
        vectors++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_done: fd=%b busy=%b, need 0 0", frame_done, busy);
        end
        step();
    endtask

    task automatic test_random_frames();
        logic [21:0] m;
        for (int n = 0; n < 8; n++) begin
            m = 22'($urandom());
            if (m == 22'h0) m = 22'h1;
            run_frame(m, 4'($urandom()), $urandom_range(0, 40), -1, 0, 1'b1);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; abort = 1'b0; continuous = 1'b0;
        ch_mask = '0; burst_len = '0; out_ready = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_continuous_stop();
        test_continuous_restart();
        test_mask_err();
        test_abort();
        test_reset_mid_stream();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
